syndrome_engine: RTL and testbench

SYNDROME_ENGINE -- requirements
Module: syndrome_engine

---
 rtl/syndrome_engine_pkg.sv | 19 +
 rtl/syndrome_engine_if.sv | 23 ++
 rtl/syndrome_engine_gf_const_mul.sv | 20 ++
 rtl/syndrome_engine.sv | 80 ++++++++
 tb/tb_syndrome_engine.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/syndrome_engine_pkg.sv
// rs_pkg: shared Reed-Solomon defaults, FSM state types and GF(2^M) power helper
package rs_pkg;
  localparam int RS_M = 8;
  localparam int RS_N = 255;
  localparam int RS_T = 8;
  localparam int RS_FCR = 0;
  localparam logic [12:0] RS_POLY = 13'h11D;
  typedef enum logic {IN_IDLE, IN_ACCUM} in_state_t;
  typedef enum logic {OUT_EMPTY, OUT_DRAIN} out_state_t;
  function automatic logic [11:0] gf_alpha_pow(input int exp, input int m, input logic [12:0] poly);
    logic [12:0] r;
    r = 13'd1;
    for (int i = 0; i < exp % ((1 << m) - 1); i++) begin
      r = r << 1;
      if (r[m]) r = r ^ poly;
    end
    return r[11:0];
  endfunction
endpackage

// File: rtl/syndrome_engine_if.sv
// syndrome_engine_if: symbol input stream and syndrome output stream bundle
interface syndrome_engine_if import rs_pkg::*; #(parameter int M = RS_M, parameter int T = RS_T);
  localparam int IW = $clog2(2 * T);
  logic sof_in;
  logic data_valid_in;
  logic [M-1:0] data_in;
  logic data_ready_out;
  logic synd_valid_out;
  logic synd_ready_in;
  logic [M-1:0] synd_out;
  logic [IW-1:0] synd_idx_out;
  logic synd_last_out;
  logic no_error_out;
  logic frame_err_out;
  modport master (
    output sof_in, data_valid_in, data_in, synd_ready_in,
    input data_ready_out, synd_valid_out, synd_out, synd_idx_out, synd_last_out, no_error_out, frame_err_out
  );
  modport slave (
    input sof_in, data_valid_in, data_in, synd_ready_in,
    output data_ready_out, synd_valid_out, synd_out, synd_idx_out, synd_last_out, no_error_out, frame_err_out
  );
endinterface

// File: rtl/syndrome_engine_gf_const_mul.sv
// gf_const_mul: combinational GF(2^M) multiply by a fixed constant
module gf_const_mul import rs_pkg::*; #(
  parameter int M = RS_M,
  parameter logic [12:0] PRIM_POLY = RS_POLY,
  parameter logic [11:0] C = 12'd1
) (
  input  logic [M-1:0] a,
  output logic [M-1:0] y
);
  logic [M-1:0] t;
  // sum of a[i] * (C * alpha^i); t walks C * alpha^i
  always_comb begin
    y = '0;
    t = C[M-1:0];
    for (int i = 0; i < M; i++) begin
      y = a[i] ? y ^ t : y;
      t = {t[M-2:0], 1'b0} ^ (t[M-1] ? PRIM_POLY[M-1:0] : '0);
    end
  end
endmodule

// File: rtl/syndrome_engine.sv
// syndrome_engine: streaming Reed-Solomon syndrome calculator with buffered drain
module syndrome_engine import rs_pkg::*; #(
  parameter int M = RS_M,
  parameter int N = RS_N,
  parameter int T = RS_T,
  parameter logic [12:0] PRIM_POLY = RS_POLY,
  parameter int FCR = RS_FCR
) (
  input logic clk_in,
  input logic rst_in,
  syndrome_engine_if.slave bus
);
  localparam int TT = 2 * T;
  localparam int IW = $clog2(TT);
  localparam int CW = $clog2(N + 1);
  in_state_t in_q, in_d;
  out_state_t out_q, out_d;
  logic [CW-1:0] cnt_q;
  logic [IW-1:0] idx_q, idx_d;
  logic [TT-1:0][M-1:0] s_q, s_mul, s_nxt, buf_q;
  logic no_err_q, frame_err_q;
  logic ready, acc, last_pos, hs, fin_hs, load;
  for (genvar j = 0; j < TT; j++) begin : g_mul
    gf_const_mul #(.M(M), .PRIM_POLY(PRIM_POLY), .C(gf_alpha_pow(FCR + j, M, PRIM_POLY))) u_mul (
      .a(s_q[j]),
      .y(s_mul[j])
    );
  end
  assign last_pos = in_q == IN_ACCUM && cnt_q == CW'(N - 1);
  assign hs = bus.synd_valid_out && bus.synd_ready_in;
  assign fin_hs = hs && idx_q == IW'(TT - 1);
  assign ready = !(last_pos && out_q == OUT_DRAIN && !fin_hs);
  assign acc = bus.data_valid_in && ready;
  assign load = acc && !bus.sof_in && last_pos;
  // next-state for both FSMs and the Horner update of every syndrome
  always_comb begin
    in_d = acc && bus.sof_in ? IN_ACCUM : load ? IN_IDLE : in_q;
    out_d = load ? OUT_DRAIN : fin_hs ? OUT_EMPTY : out_q;
    idx_d = fin_hs || load ? '0 : hs ? idx_q + 1'b1 : idx_q;
    s_nxt = '0;
    for (int i = 0; i < TT; i++) s_nxt[i] = bus.sof_in ? bus.data_in : s_mul[i] ^ bus.data_in;
  end
  // FSM state registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      in_q <= IN_IDLE;
      out_q <= OUT_EMPTY;
      idx_q <= '0;
    end else begin
      in_q <= in_d;
      out_q <= out_d;
      idx_q <= idx_d;
    end
  end
  // accumulators, symbol counter, output buffer and status flags
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q <= '0;
      s_q <= '0;
      buf_q <= '0;
      no_err_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= acc && (bus.sof_in ? in_q == IN_ACCUM : in_q == IN_IDLE);
      if (acc && (bus.sof_in || in_q == IN_ACCUM)) s_q <= s_nxt;
      cnt_q <= acc && bus.sof_in ? CW'(1) : load ? '0 : acc && in_q == IN_ACCUM ? cnt_q + 1'b1 : cnt_q;
      if (load) begin
        buf_q <= s_nxt;
        no_err_q <= ~|s_nxt;
      end
    end
  end
  assign bus.data_ready_out = ready;
  assign bus.synd_valid_out = out_q == OUT_DRAIN;
  assign bus.synd_out = buf_q[idx_q];
  assign bus.synd_idx_out = idx_q;
  assign bus.synd_last_out = out_q == OUT_DRAIN && idx_q == IW'(TT - 1);
  assign bus.no_error_out = no_err_q;
  assign bus.frame_err_out = frame_err_q;
endmodule

// File: tb/tb_syndrome_engine.sv
// tb_syndrome_engine: directed-vector bench for syndrome_engine at default parameters
module tb_syndrome_engine;
  logic clk_in = 0;
  logic rst_in = 1;
  int total = 0;
  int bad = 0;
  logic [7:0] e_zero[16];
  logic [7:0] e_5a[16];
  logic [7:0] e_alpha[16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                              8'h1D, 8'h3A, 8'h74, 8'hE8, 8'hCD, 8'h87, 8'h13, 8'h26};
  syndrome_engine_if bus ();
  syndrome_engine u_dut (.clk_in(clk_in), .rst_in(rst_in), .bus(bus));
  always #5 clk_in = ~clk_in;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
    end
  endtask
  task automatic send_sym(input logic s, input logic [7:0] d);
    int w = 0;
    bus.sof_in = s;
    bus.data_valid_in = 1;
    bus.data_in = d;
    while (!bus.data_ready_out && w < 100) begin
      tick(1);
      w++;
    end
    if (!bus.data_ready_out) chk("ready_timeout", bus.data_ready_out, 1);
    tick(1);
    bus.data_valid_in = 0;
    bus.sof_in = 0;
  endtask
  task automatic send_frame(input int first, input int last, input int pos, input logic [7:0] val);
    for (int i = first; i <= last; i++) send_sym(i == 1, i == pos ? val : 8'h00);
  endtask
  task automatic drain(input logic [7:0] e[16], input int n, input logic ne);
    bus.synd_ready_in = 1;
    for (int i = 0; i < n; i++) begin
      int w = 0;
      while (!bus.synd_valid_out && w < 50) begin
        tick(1);
        w++;
      end
      chk("synd_valid", bus.synd_valid_out, 1);
      chk("synd_idx", bus.synd_idx_out, i);
      chk("synd", bus.synd_out, e[i]);
      chk("synd_last", bus.synd_last_out, i == 15);
      if (i == 0) chk("no_error", bus.no_error_out, ne);
      tick(1);
    end
    bus.synd_ready_in = 0;
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, bus.synd_valid_out, 0);
    chk({tag, "_ready"}, bus.data_ready_out, 1);
    chk({tag, "_synd"}, bus.synd_out, 0);
    chk({tag, "_idx"}, bus.synd_idx_out, 0);
    chk({tag, "_last"}, bus.synd_last_out, 0);
    chk({tag, "_noerr"}, bus.no_error_out, 0);
    chk({tag, "_ferr"}, bus.frame_err_out, 0);
  endtask
  initial begin
    for (int i = 0; i < 16; i++) begin
      e_zero[i] = 8'h00;
      e_5a[i] = 8'h5A;
    end
    bus.sof_in = 0;
    bus.data_valid_in = 0;
    bus.data_in = 0;
    bus.synd_ready_in = 0;
    tick(3);
    chk_reset_outputs("rst");
    rst_in = 0;
    tick(2);
    send_frame(1, 255, 0, 8'h00);
    drain(e_zero, 16, 1);
    chk("zero_done_valid", bus.synd_valid_out, 0);
    send_frame(1, 199, 50, 8'hAB);
    rst_in = 1;
    #2;
    chk_reset_outputs("rst_frame");
    rst_in = 0;
    tick(20);
    chk("rst_frame_quiet", bus.synd_valid_out, 0);
    send_frame(1, 255, 255, 8'h5A);
    drain(e_5a, 16, 0);
    send_frame(1, 255, 254, 8'h01);
    drain(e_alpha, 16, 0);
    send_frame(1, 255, 255, 8'h5A);
    send_frame(1, 254, 254, 8'h01);
    bus.sof_in = 0;
    bus.data_valid_in = 1;
    bus.data_in = 8'h00;
    #1;
    chk("b2b_stall", bus.data_ready_out, 0);
    tick(3);
    chk("b2b_stall_hold", bus.data_ready_out, 0);
    chk("b2b_idx_hold", bus.synd_idx_out, 0);
    drain(e_5a, 16, 0);
    bus.data_valid_in = 0;
    chk("b2b_reload_valid", bus.synd_valid_out, 1);
    drain(e_alpha, 16, 0);
    chk("b2b_done_valid", bus.synd_valid_out, 0);
    send_sym(1, 8'h33);
    for (int i = 2; i < 100; i++) send_sym(0, 8'h33);
    chk("sof100_pre", bus.frame_err_out, 0);
    send_frame(1, 1, 0, 8'h00);
    chk("sof100_pulse", bus.frame_err_out, 1);
    send_frame(2, 2, 0, 8'h00);
    chk("sof100_pulse_end", bus.frame_err_out, 0);
    send_frame(3, 255, 255, 8'h5A);
    drain(e_5a, 16, 0);
    send_sym(0, 8'h77);
    chk("idle_drop_pulse", bus.frame_err_out, 1);
    tick(1);
    chk("idle_drop_pulse_end", bus.frame_err_out, 0);
    tick(5);
    chk("idle_drop_quiet", bus.synd_valid_out, 0);
    send_frame(1, 255, 255, 8'h5A);
    drain(e_5a, 7, 0);
    chk("pre_rst_idx", bus.synd_idx_out, 7);
    rst_in = 1;
    #2;
    chk_reset_outputs("rst_drain");
    rst_in = 0;
    tick(20);
    chk("rst_drain_quiet", bus.synd_valid_out, 0);
    send_frame(1, 255, 254, 8'h01);
    drain(e_alpha, 16, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
